// File: rtl/div_pkg.sv
// Shared constants for the divider and its sign-fixup / HI-LO stage.
// Holds the default datapath width and the fixup FSM state encodings.
package div_pkg;

    localparam int DIV_WIDTH = 32;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_FIX   = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_HOLD  = 2'd3;

endpackage

// File: rtl/div_sign_fixup_hilo_twos_neg.sv
// Combinational two's-complement negation (invert plus one).
// Ports: a (operand), y (negated result), both WIDTH bits.
module twos_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] y
);

    assign y = ~a + WIDTH'(1);

endmodule

// File: rtl/div_sign_fixup_hilo.sv
// Sign fixup of an unsigned divider result and HI/LO register file.
// Ports: clk/clr, in_valid/in_ready + quo/rem/sign/dz inputs,
// out_valid/out_ready + hi/lo/dz_flag, hi_wr/lo_wr/wdata direct write.
module div_sign_fixup_hilo
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH:0]   rem,
    input  logic             dvd_neg,
    input  logic             dvs_neg,
    input  logic             div_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             dz_flag,
    input  logic             hi_wr,
    input  logic             lo_wr,
    input  logic [WIDTH-1:0] wdata
);

    logic [1:0]       state;

    logic [WIDTH-1:0] l_quo;
    logic [WIDTH-1:0] l_rem;
    logic             l_dvd_neg;
    logic             l_dvs_neg;
    logic             l_dz;

    logic [WIDTH-1:0] f_lo;
    logic [WIDTH-1:0] f_hi;
    logic             f_dz;

    logic [WIDTH-1:0] quo_n;
    logic [WIDTH-1:0] rem_n;
    logic [WIDTH-1:0] fix_lo;
    logic [WIDTH-1:0] fix_hi;

    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             ov_q;
    logic             dz_q;

    // The divider's extra remainder bit carries no information here.
    logic             rem_top_unused;
    assign rem_top_unused = rem[WIDTH];

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = ov_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign dz_flag   = dz_q;

    twos_neg #(.WIDTH(WIDTH)) u_neg_quo (
        .a (l_quo),
        .y (quo_n)
    );

    twos_neg #(.WIDTH(WIDTH)) u_neg_rem (
        .a (l_rem),
        .y (rem_n)
    );

    // Truncating division: quotient sign is the XOR of operand signs,
    // remainder follows the dividend. Divide-by-zero bypasses both.
    always_comb begin
        fix_lo = l_quo;
        fix_hi = l_rem;
        if (l_dz) begin
            fix_lo = '1;
            fix_hi = l_rem;
        end else begin
            if (l_dvd_neg ^ l_dvs_neg)
                fix_lo = quo_n;
            if (l_dvd_neg)
                fix_hi = rem_n;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state     <= ST_IDLE;
            l_quo     <= '0;
            l_rem     <= '0;
            l_dvd_neg <= 1'b0;
            l_dvs_neg <= 1'b0;
            l_dz      <= 1'b0;
            f_lo      <= '0;
            f_hi      <= '0;
            f_dz      <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            ov_q      <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        l_quo     <= quo;
                        l_rem     <= rem[WIDTH-1:0];
                        l_dvd_neg <= dvd_neg;
                        l_dvs_neg <= dvs_neg;
                        l_dz      <= div_zero;
                        state     <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    f_lo  <= fix_lo;
                    f_hi  <= fix_hi;
                    f_dz  <= l_dz;
                    state <= ST_WRITE;
                end
                ST_WRITE: begin
                    hi_q  <= f_hi;
                    lo_q  <= f_lo;
                    dz_q  <= f_dz;
                    ov_q  <= 1'b1;
                    state <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        ov_q  <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Move-to-HI/LO loses to the division load in WRITE.
            if (state != ST_WRITE) begin
                if (hi_wr)
                    hi_q <= wdata;
                if (lo_wr)
                    lo_q <= wdata;
            end
        end
    end

endmodule

// File: tb/tb_div_sign_fixup_hilo.sv
// Self-checking bench for div_sign_fixup_hilo (WIDTH=32).
// Scoreboard queue of expected HI/LO/dz pushed on accept, popped on out_valid.
module tb_div_sign_fixup_hilo;

    logic        clk;
    logic        clr;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] quo;
    logic [32:0] rem;
    logic        dvd_neg;
    logic        dvs_neg;
    logic        div_zero;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz_flag;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] wdata;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    int   checks;
    int   errors;

    div_sign_fixup_hilo #(.WIDTH(32)) dut (
        .clk       (clk),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .quo       (quo),
        .rem       (rem),
        .dvd_neg   (dvd_neg),
        .dvs_neg   (dvs_neg),
        .div_zero  (div_zero),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .hi        (hi),
        .lo        (lo),
        .dz_flag   (dz_flag),
        .hi_wr     (hi_wr),
        .lo_wr     (lo_wr),
        .wdata     (wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic exp_t model(input logic [31:0] q, input logic [32:0] r,
                                   input logic dn, input logic sn,
                                   input logic dz);
        exp_t        e;
        logic [31:0] r32;
        r32 = r[31:0];
        if (dz) begin
            e.lo = 32'hFFFF_FFFF;
            e.hi = r32;
            e.dz = 1'b1;
        end else begin
            e.lo = (dn ^ sn) ? (32'd0 - q) : q;
            e.hi = dn ? (32'd0 - r32) : r32;
            e.dz = 1'b0;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at #1 after a rising edge with the DUT in IDLE.
    task automatic start(input logic [31:0] q, input logic [32:0] r,
                         input logic dn, input logic sn, input logic dz,
                         input bit push);
        in_valid = 1'b1;
        quo      = q;
        rem      = r;
        dvd_neg  = dn;
        dvs_neg  = sn;
        div_zero = dz;
        if (push)
            sb.push_back(model(q, r, dn, sn, dz));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        quo      = $urandom;
        rem      = {1'b1, $urandom};
        dvd_neg  = ~dn;
        dvs_neg  = ~sn;
        div_zero = ~dz;
    endtask

    task automatic wait_out(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 8) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd2);
    endtask

    task automatic check_out(input string tag);
        exp_t e;
        chk({tag, "_sb"}, 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_lo"}, 64'(lo), 64'(e.lo));
            chk({tag, "_hi"}, 64'(hi), 64'(e.hi));
            chk({tag, "_dz"}, 64'(dz_flag), 64'(e.dz));
        end
    endtask

    task automatic complete(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_ov0"}, 64'(out_valid), 64'd0);
        chk({tag, "_rdy"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        clr       = 1'b1;
        in_valid  = 1'b0;
        quo       = '0;
        rem       = '0;
        dvd_neg   = 1'b0;
        dvs_neg   = 1'b0;
        div_zero  = 1'b0;
        out_ready = 1'b0;
        hi_wr     = 1'b0;
        lo_wr     = 1'b0;
        wdata     = '0;

        repeat (2) @(posedge clk);
        #1;
        clr = 1'b0;
        chk("rst_rdy", 64'(in_ready), 64'd1);
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_lo", 64'(lo), 64'd0);
        chk("rst_dz", 64'(dz_flag), 64'd0);

        // Negative dividend, positive divisor.
        start(32'd3, 33'd1, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t1_busy", 64'(in_ready), 64'd0);
        wait_out("t1");
        check_out("t1");
        complete("t1");

        // Both negative.
        start(32'd3, 33'd1, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_out("t2");
        check_out("t2");
        complete("t2");

        // Divide by zero, then a normal result clears the flag.
        start(32'd0, 33'd5, 1'b0, 1'b1, 1'b1, 1'b1);
        wait_out("t3");
        check_out("t3");
        complete("t3");
        start(32'd7, 33'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_out("t4");
        check_out("t4");
        complete("t4");

        // Overflow quotient passes through; remainder bit 32 ignored.
        start(32'h8000_0000, 33'h1_0000_0004, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_out("t5");
        check_out("t5");
        complete("t5");

        // Positive dividend, negative divisor.
        start(32'd100, 33'd9, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_out("t6");
        check_out("t6");
        complete("t6");

        // Backpressure: four stalled cycles with a competing in_valid.
        start(32'h0000_1357, 33'h0_0000_0011, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_out("t7");
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            quo      = 32'hDEAD_0000 + 32'(i);
            rem      = 33'd77;
            div_zero = 1'b1;
            @(posedge clk);
            #1;
            chk("t7_hold_ov", 64'(out_valid), 64'd1);
            chk("t7_hold_rdy", 64'(in_ready), 64'd0);
        end
        in_valid = 1'b0;
        div_zero = 1'b0;
        check_out("t7");
        complete("t7");
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("t7_idle_ov", 64'(out_valid), 64'd0);
        end

        // Direct HI write in IDLE leaves LO alone.
        hi_wr = 1'b1;
        wdata = 32'h0000_ABCD;
        @(posedge clk);
        #1;
        hi_wr = 1'b0;
        chk("t8_hi", 64'(hi), 64'h0000_ABCD);
        chk("t8_lo", 64'(lo), 64'hFFFF_ECA9);

        // Clear while in FIX drops the in-flight result.
        start(32'd9, 33'd4, 1'b0, 1'b0, 1'b0, 1'b0);
        clr = 1'b1;
        #1;
        chk("t9_hi", 64'(hi), 64'd0);
        chk("t9_lo", 64'(lo), 64'd0);
        chk("t9_ov", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        clr = 1'b0;
        chk("t9_rdy", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            chk("t9_drop", 64'(out_valid), 64'd0);
        end

        // LO write colliding with WRITE loses; the same write in HOLD wins.
        start(32'd6, 33'd3, 1'b0, 1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        lo_wr = 1'b1;
        wdata = 32'h0000_1234;
        @(posedge clk);
        #1;
        chk("t10_ov", 64'(out_valid), 64'd1);
        check_out("t10");
        @(posedge clk);
        #1;
        lo_wr = 1'b0;
        chk("t10_lo_hold", 64'(lo), 64'h0000_1234);
        chk("t10_hi_hold", 64'(hi), 64'd3);
        complete("t10");

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/div_sign_fixup_hilo.md
DIV_SIGN_FIXUP_HILO -- requirements
Module: div_sign_fixup_hilo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the datapath width of quotient, remainder, HI and LO.
REQ-002 The block SHALL have port clk, input, 1, single system clock; all state changes on rising edge.
REQ-003 The block SHALL have port clr, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, the unsigned-divider result is valid this cycle.
REQ-005 The block SHALL have port in_ready, output, 1, the block can accept a result this cycle.
REQ-006 The block SHALL have port quo, input, WIDTH, the unsigned quotient.
REQ-007 The block SHALL have port rem, input, WIDTH+1, the unsigned remainder; bit WIDTH is ignored.
REQ-008 The block SHALL have port dvd_neg, input, 1, the original dividend was negative (signed op).
REQ-009 The block SHALL have port dvs_neg, input, 1, the original divisor was negative (signed op).
REQ-010 The block SHALL have port div_zero, input, 1, the divisor was zero.
REQ-011 The block SHALL have port out_valid, output, 1, HI/LO hold a new division result.
REQ-012 The block SHALL have port out_ready, input, 1, the consumer has taken the result.
REQ-013 The block SHALL have port hi, output, WIDTH, the HI register (signed remainder).
REQ-014 The block SHALL have port lo, output, WIDTH, the LO register (signed quotient).
REQ-015 The block SHALL have port dz_flag, output, 1, a sticky divide-by-zero flag for the last accepted result.
REQ-016 The block SHALL have ports hi_wr and lo_wr (input, 1 each) and wdata (input, WIDTH), giving a direct register write port for move-to-HI/LO.

Function
REQ-017 The FSM SHALL have states IDLE, FIX, WRITE and HOLD; in_ready SHALL equal 1 only in IDLE.
REQ-018 In IDLE with in_valid=1 the block SHALL latch all inputs and enter FIX at that edge (edge N).
REQ-019 FIX SHALL register the corrected values and enter WRITE at edge N+1.
REQ-020 In WRITE, hi and lo SHALL be loaded at edge N+2, out_valid SHALL be set, and the FSM SHALL enter HOLD; total latency SHALL be 2 cycles.
REQ-021 HOLD SHALL keep out_valid=1 until a cycle with out_ready=1, then return to IDLE at that edge; out_valid and out_ready both high in the same cycle is the completion point.
REQ-022 The corrected quotient SHALL be the two's-complement negation of quo when dvd_neg XOR dvs_neg, else quo unchanged.
REQ-023 The corrected remainder SHALL be rem[WIDTH-1:0], negated when dvd_neg=1 (truncating division: the remainder takes the sign of the dividend).
REQ-024 When div_zero=1, lo SHALL load all-ones, hi SHALL load rem[WIDTH-1:0] uncorrected, and dz_flag SHALL be set; otherwise dz_flag SHALL be cleared on load.
REQ-025 For the overflow case (quo=0x80000000 with equal signs), lo SHALL pass through unchanged (0x80000000) without a flag.
REQ-026 hi_wr or lo_wr SHALL update the selected register from wdata at the edge in IDLE, FIX or HOLD.
REQ-027 A hi_wr or lo_wr asserted in the same cycle as a WRITE-state load SHALL be ignored; the division write wins.
REQ-028 in_valid while not in IDLE SHALL be ignored, and the inputs SHALL NOT be re-sampled.

Reset
REQ-029 Asserting clr SHALL immediately force the state to IDLE and hi, lo, out_valid and dz_flag to 0, including mid-operation; any in-flight result SHALL be discarded.
REQ-030 After clr deasserts, in_ready SHALL be 1 on the first cycle.

Structure
REQ-031 The FSM state encodings and WIDTH SHALL live in a shared package (div_pkg) with the divider.
REQ-032 Negation SHALL be one sub-module, twos_neg (WIDTH-bit combinational invert-plus-one), instantiated twice.

Verification
REQ-033 quo=3, rem=1, dvd_neg=1, dvs_neg=0 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, out_valid 2 cycles after accept.
REQ-034 quo=3, rem=1, dvd_neg=1, dvs_neg=1 -> lo=3, hi=0xFFFFFFFF.
REQ-035 div_zero=1, rem=5 -> lo=0xFFFFFFFF, hi=5, dz_flag=1; a following normal result clears dz_flag.
REQ-036 out_ready held 0 for 4 cycles -> out_valid stays 1, in_ready stays 0, and a second in_valid is ignored.
REQ-037 clr asserted in FIX -> hi=lo=0, out_valid=0 immediately, and in_ready=1 after release.
REQ-038 lo_wr with wdata=0x1234 in the WRITE cycle -> lo holds the division result; the same lo_wr in HOLD -> lo=0x1234.
